uart_rx_pipe: RTL and testbench

Serial-to-byte receive path: an 8N1 UART receiver feeding a byte FIFO that the core drains with a single-cycle pop strobe. Sits between the board RX pin and any consumer of received bytes, typically looped into the transmit pipe. The FIFO is sized and read like a single block RAM so it maps onto one iCE40 BRAM.

---
 rtl/uart_pkg.sv | 17 +
 rtl/byte_fifo.sv | 63 ++++++
 rtl/uart_rx_pipe.sv | 132 +++++++++++++
 tb/tb_uart_rx_pipe.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART receive pipe
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - single-port-read byte FIFO shaped to map onto one block RAM
module byte_fifo #(
    parameter int DEPTH  = 512,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              overrun,
    output logic              underrun
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign overrun  = push & full;
    assign underrun = pop & empty;

    // Memory has no reset so it stays inferable as block RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            dout  <= '0;
        end else begin
            if (do_pop) begin
                dout <= mem[head];
                head <= head + AW'(1);
            end
            if (do_push) begin
                tail <= tail + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_pipe.sv
// rtl/uart_rx_pipe.sv - 8N1 UART receiver feeding a byte FIFO drained by a pop strobe
module uart_rx_pipe
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 12_000_000,
    parameter int BAUD     = 9_600,
    parameter int DEPTH    = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pop_front,
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              full,
    input  logic              rx,
    output logic              error
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    // One extra bit lets the counter hold a full DIV even when DIV is a power of two.
    localparam int CW  = $clog2(DIV + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIV);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);

    rx_state_t         state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [2:0]        bit_idx, bit_idx_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              rx_meta, rx_sync, rx_sync_d;
    logic              expire;
    logic              push;
    logic              frame_err;
    logic              overrun;
    logic              underrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_sync_d <= 1'b1;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            rx_sync_d <= rx_sync;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            error   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            error   <= frame_err | overrun | underrun;
        end
    end

    assign expire = (cnt == CW'(1));

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        push      = 1'b0;
        frame_err = 1'b0;
        if (state != IDLE && !expire) begin
            cnt_n = cnt - CW'(1);
        end
        case (state)
            IDLE: begin
                if (rx_sync_d && !rx_sync) begin
                    state_n = START;
                    cnt_n   = CNT_HALF;
                end
            end
            START: begin
                if (expire) begin
                    if (!rx_sync) begin
                        state_n   = DATA;
                        cnt_n     = CNT_FULL;
                        bit_idx_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    shreg_n = {rx_sync, shreg[DATA_W-1:1]};
                    cnt_n   = CNT_FULL;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (expire) begin
                    push      = rx_sync;
                    frame_err = ~rx_sync;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    byte_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop_front),
        .din      (shreg),
        .dout     (data_out),
        .empty    (empty),
        .full     (full),
        .overrun  (overrun),
        .underrun (underrun)
    );

endmodule

// File: tb/tb_uart_rx_pipe.sv
// tb/tb_uart_rx_pipe.sv - self-checking bench for uart_rx_pipe against a queue model
module tb_uart_rx_pipe;

    localparam int CLK_FREQ = 200;
    localparam int BAUD     = 10;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int DEPTH    = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       pop_front;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
    logic       rx;
    logic       error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_cnt = 0;
    int exp_err = 0;
    int start_cyc = 0;
    int fill_cyc = -1;
    int lat = 0;
    logic empty_q = 1'b1;
    logic [7:0] exp_data = 8'h00;
    logic [7:0] q[$];

    uart_rx_pipe #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pop_front (pop_front),
        .data_out  (data_out),
        .empty     (empty),
        .full      (full),
        .rx        (rx),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (error === 1'b1) err_cnt = err_cnt + 1;
        if (empty_q === 1'b1 && empty === 1'b0) fill_cyc = cyc;
        empty_q = empty;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int pop_at);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        start_cyc = cyc;
        for (int c = 0; c < 10 * DIV; c++) begin
            rx = fr[c / DIV];
            pop_front = (c == pop_at);
            @(posedge clk);
            #1;
        end
        pop_front = 1'b0;
        rx = 1'b1;
        if (!stop) exp_err++;
        else if (q.size() == DEPTH) exp_err++;
        else q.push_back(b);
    endtask

    task automatic do_pop(input string tag);
        pop_front = 1'b1;
        @(posedge clk);
        #1;
        pop_front = 1'b0;
        if (q.size() > 0) exp_data = q.pop_front();
        else exp_err++;
        check({tag, "_data"}, 32'(data_out), 32'(exp_data));
        check({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
        check({tag, "_full"}, 32'(full), 32'(q.size() == DEPTH));
    endtask

    task automatic check_err(input string tag);
        repeat (2) @(posedge clk);
        #1;
        check(tag, 32'(err_cnt), 32'(exp_err));
    endtask

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        pop_front = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_full", 32'(full), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        rst = 1'b0;

        // Abort a frame part-way through with reset, then receive a clean one.
        rx = 1'b0;
        repeat (3 * DIV) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_empty", 32'(empty), 32'h1);
        check("mid_rst_full", 32'(full), 32'h0);
        check("mid_rst_data", 32'(data_out), 32'h0);
        check("mid_rst_error", 32'(error), 32'h0);
        @(posedge clk);
        #1;
        rx = 1'b1;
        rst = 1'b0;
        repeat (2 * DIV) @(posedge clk);
        #1;
        check("mid_rst_still_empty", 32'(empty), 32'h1);
        send_byte(8'h41, 1'b1, -1);
        do_pop("pop_41");
        check_err("err_after_41");

        // Single frame latency from start edge to empty falling.
        fill_cyc = -1;
        send_byte(8'hA5, 1'b1, -1);
        lat = fill_cyc - start_cyc;
        check("lat_window", 32'(lat >= 9 * DIV && lat <= 10 * DIV), 32'h1);
        do_pop("pop_a5");

        send_byte(8'h01, 1'b1, -1);
        send_byte(8'h02, 1'b1, -1);
        send_byte(8'h03, 1'b1, -1);
        do_pop("pop_01");
        do_pop("pop_02");
        do_pop("pop_03");
        check_err("err_after_123");

        // Fill to capacity with random bytes, then overrun once.
        for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 1'b1, -1);
        check("fill_full", 32'(full), 32'h1);
        check("fill_empty", 32'(empty), 32'h0);
        send_byte(8'($urandom), 1'b1, -1);
        check_err("err_overrun");
        check("overrun_full", 32'(full), 32'h1);
        for (int i = 0; i < DEPTH; i++) do_pop($sformatf("drain%0d", i));
        check_err("err_after_drain");

        send_byte(8'h55, 1'b0, -1);
        repeat (DIV) @(posedge clk);
        #1;
        check_err("err_framing");
        check("framing_empty", 32'(empty), 32'h1);

        // Glitch shorter than half a bit is rejected silently.
        rx = 1'b0;
        repeat (DIV / 2 - 4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (2 * DIV) @(posedge clk);
        #1;
        check("glitch_empty", 32'(empty), 32'h1);
        check_err("err_glitch");

        do_pop("pop_underrun");
        check_err("err_underrun");

        // Pop aligned with the push edge while one byte is queued.
        send_byte(8'h3C, 1'b1, -1);
        if (lat < 9 * DIV || lat > 10 * DIV) lat = 9 * DIV + DIV / 2;
        exp_data = q.pop_front();
        send_byte(8'hC3, 1'b1, lat - 1);
        check("simul_data", 32'(data_out), 32'(exp_data));
        check("simul_empty", 32'(empty), 32'h0);
        check("simul_full", 32'(full), 32'h0);
        check_err("err_simul");
        do_pop("pop_c3");
        check_err("err_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
